pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter stage of the single-cycle MIPS datapath, directly upstream of instruction memory. Holds the byte-address PC and drives it into the memory address port. Computes the next PC from the decoder's PCSel/BranchControl/AdderValControl, the ALU zero flag, the jump field and the rs register value. Adds stall, halt and misaligned-jr handling through a small run-control state machine.

## Interface
- RESET_PC, default 32'h0000_0000: PC value loaded on reset.
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- PCSel  in  2  next-PC source: 00 jump (j/jal), 01 register (jr), 10 sequential/branch, 11 reserved (treated as 10).
- BranchControl  in  1  0 = bne-type conditional branch instruction, 1 = no conditional branch.
- AdderValControl  in  1  1 = unconditional PC-relative branch (branch offset always added).
- zero  in  1  ALU zero flag for the current instruction.
- instr  in  26  instruction bits [25:0] (jump target; [15:0] = branch immediate).
- regRs  in  32  rs register read value (jr target).
- stall  in  1  hold PC this cycle.
- halt  in  1  request permanent stop.
- pc  out  32  current PC, byte address; low 10 bits feed instruction memory Addr.
- pcPlus4  out  32  pc + 4 (jal link value).
- fetchValid  out  1  high when state is RUN and the current pc is a live fetch.
- halted  out  1  high in HALT state.
- misalignFault  out  1  sticky: a jr target had regRs[1:0] != 0.

## Operation
- Combinational: pcPlus4 = pc + 4 (mod 2^32); brTarget = pcPlus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}) (mod 2^32); jTarget = {pcPlus4[31:28], instr[25:0], 2'b00}.
- takeBranch = AdderValControl | (~BranchControl & ~zero).
- nextPc: PCSel 00 -> jTarget; 01 -> {regRs[31:2], 2'b00}; 10/11 -> takeBranch ? brTarget : pcPlus4.
- States: BOOT, RUN, STALL, HALT (2-bit encoding).
- BOOT: entered on reset; pc = RESET_PC; fetchValid = 0; next cycle -> RUN unconditionally (one bubble so decoder latches the first instruction on negedge).
- RUN: pc <= nextPc each posedge. If halt -> HALT (pc not updated). Else if PCSel==01 and regRs[1:0]!=0 -> set misalignFault, -> HALT (pc not updated). Else if stall -> STALL (pc not updated).
- STALL: pc held; fetchValid = 0; halt -> HALT; stall low -> RUN (no PC update on that edge; next edge advances).
- HALT: absorbing; pc held; only reset exits.
- Priority at one edge: reset > halt > misalign > stall > advance.
- Wrap-around: pc 32'hFFFF_FFFC advancing sequentially becomes 32'h0000_0000; no flag.

## Timing
- Reset (async assert): pc = RESET_PC, state = BOOT, fetchValid = 0, halted = 0, misalignFault = 0, retired = 0 immediately, independent of clk.
- Reset deassertion synchronous to first posedge; first PC advance occurs on the second posedge after release.
- Next-PC latency: 1 cycle; inputs sampled at posedge, pc valid after that edge. Decoder outputs are settled by posedge since they update on negedge.
- stall and halt are level-sensitive, sampled at posedge only.
- pcPlus4 is combinational from pc, zero-cycle.

## Configuration
- PC_RETIRE_COUNT_EN: when defined, adds output retired (32 bits, reset 0). It increments by 1 on every posedge on which pc advances in RUN, and wraps at 2^32. When undefined, the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then 3 cycles with PCSel=10, BranchControl=1: pc sequence 0 (BOOT), 0, 4, 8; fetchValid 0,1,1,1.
- bne at pc=8, instr[15:0]=16'hFFFE, BranchControl=0: zero=0 -> pc=4; repeat with zero=1 -> pc=12.
- j at pc=32'h1000_0010, instr=26'h000_0040: pc=32'h1000_0100; pcPlus4 before the edge = 32'h1000_0014.
- jr with regRs=32'h0000_0203: misalignFault=1, halted=1, pc stays put; assert rst_n=0 mid-cycle -> all outputs reset immediately.
- stall held 2 cycles at pc=20: pc 20,20,20 then 24; stall and halt asserted on the same edge -> HALT, pc 20.
- With PC_RETIRE_COUNT_EN: pc=32'hFFFF_FFFC sequential -> pc=0, retired increments by exactly 1; stalled cycles do not increment retired.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the fetch PC, computes the next PC and runs a
// BOOT/RUN/STALL/HALT run-control FSM. Optional macro PC_RETIRE_COUNT_EN adds
// the 32-bit 'retired' advance counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PCSel,
  input  logic        BranchControl,
  input  logic        AdderValControl,
  input  logic        zero,
  input  logic [25:0] instr,
  input  logic [31:0] regRs,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        fetchValid,
  output logic        halted,
  output logic        misalignFault,
  output logic [1:0]  state_dbg
`ifdef PC_RETIRE_COUNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic        take_branch;
  logic        jr_misaligned;
  logic [31:0] next_pc;
  logic        advance;

  // Next-PC datapath; PCSel 11 is reserved and behaves like 10.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    br_offset     = {{14{instr[15]}}, instr[15:0], 2'b00};
    br_target     = pc_plus4 + br_offset;
    j_target      = {pc_plus4[31:28], instr, 2'b00};
    jr_target     = {regRs[31:2], 2'b00};
    take_branch   = AdderValControl | (~BranchControl & ~zero);
    jr_misaligned = (PCSel == 2'b01) && (regRs[1:0] != 2'b00);
    next_pc       = take_branch ? br_target : pc_plus4;
    case (PCSel)
      2'b00:   next_pc = j_target;
      2'b01:   next_pc = jr_target;
      default: next_pc = take_branch ? br_target : pc_plus4;
    endcase
  end

  // Edge priority inside RUN: halt > misaligned jr > stall > advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    advance = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (jr_misaligned) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else if (stall) begin
          state_d = ST_STALL;
        end else begin
          pc_d    = next_pc;
          advance = 1'b1;
        end
      end
      ST_STALL: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

`ifdef PC_RETIRE_COUNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (advance) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

  // fetchValid qualifies pc: instruction memory output is live only while it is high.
  assign pc            = pc_q;
  assign pcPlus4       = pc_plus4;
  assign fetchValid    = (state_q == ST_RUN);
  assign halted        = (state_q == ST_HALT);
  assign misalignFault = fault_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  PCSel = 2'b10;
  logic        BranchControl = 1'b1;
  logic        AdderValControl = 1'b0;
  logic        zero = 1'b0;
  logic [25:0] instr = '0;
  logic [31:0] regRs = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        fetchValid;
  logic        halted;
  logic        misalignFault;
  logic [1:0]  state_dbg;
`ifdef PC_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PCSel(PCSel), .BranchControl(BranchControl),
    .AdderValControl(AdderValControl), .zero(zero), .instr(instr), .regRs(regRs),
    .stall(stall), .halt(halt), .pc(pc), .pcPlus4(pcPlus4), .fetchValid(fetchValid),
    .halted(halted), .misalignFault(misalignFault), .state_dbg(state_dbg)
`ifdef PC_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc = 32'h0;
  logic        m_boot = 1'b1;
  logic        m_stalled = 1'b0;
  logic        m_halted = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_ret = 32'h0;

  function automatic logic [31:0] model_next(input logic [31:0] cur);
    longint p4;
    longint off;
    p4 = (longint'(cur) + 4) % 64'h1_0000_0000;
    off = longint'($signed(instr[15:0])) * 4;
    if (PCSel == 2'd0)
      return 32'((p4 / 64'h1000_0000) * 64'h1000_0000 + longint'(instr) * 4);
    if (PCSel == 2'd1)
      return 32'((longint'(regRs) / 4) * 4);
    if (AdderValControl || (!BranchControl && !zero))
      return 32'((p4 + off + 64'h1_0000_0000) % 64'h1_0000_0000);
    return 32'(p4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_boot <= 1'b1; m_stalled <= 1'b0;
      m_halted <= 1'b0; m_fault <= 1'b0; m_ret <= 32'h0;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (m_stalled) begin
      if (halt) begin
        m_halted <= 1'b1; m_stalled <= 1'b0;
      end else if (!stall) begin
        m_stalled <= 1'b0;
      end
    end else if (halt) begin
      m_halted <= 1'b1;
    end else if (PCSel == 2'd1 && (regRs % 4) != 0) begin
      m_fault <= 1'b1; m_halted <= 1'b1;
    end else if (stall) begin
      m_stalled <= 1'b1;
    end else begin
      m_pc <= model_next(m_pc);
      m_ret <= m_ret + 32'd1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("pcPlus4", pcPlus4, m_pc + 32'd4);
      check("fetchValid", 32'(fetchValid), 32'(!m_boot && !m_stalled && !m_halted));
      check("halted", 32'(halted), 32'(m_halted));
      check("misalignFault", 32'(misalignFault), 32'(m_fault));
`ifdef PC_RETIRE_COUNT_EN
      check("retired", retired, m_ret);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [1:0] sel, input logic bc, input logic avc, input logic z,
                        input logic [25:0] ins, input logic [31:0] rs, input logic st, input logic hl);
    PCSel = sel; BranchControl = bc; AdderValControl = avc; zero = z;
    instr = ins; regRs = rs; stall = st; halt = hl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seq_step();
    set_in(2'b10, 1'b1, 1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic jr_to(input logic [31:0] target);
    set_in(2'b01, 1'b1, 1'b0, 1'b0, 26'h0, target, 1'b0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(2'b10, 1'b1, 1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] ret_before;

  initial begin
    ret_before = 32'h0;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_pc", pc, 32'h0);
    check("reset_fetchValid", 32'(fetchValid), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    rst_n = 1'b1;

    // Boot bubble then sequential run: 0,4,8.
    check("boot_pc", pc, 32'h0);
    seq_step();
    check("run_pc0", pc, 32'h0);
    check("run_fv", 32'(fetchValid), 32'h1);
    seq_step();
    check("seq_pc4", pc, 32'h4);
    seq_step();
    check("seq_pc8", pc, 32'h8);

    // bne at pc=8 with offset -2 words.
    set_in(2'b10, 1'b0, 1'b0, 1'b0, 26'h000_FFFE, 32'h0, 1'b0, 1'b0);
    tick();
    check("bne_taken", pc, 32'h4);
    seq_step();
    check("back_to_8", pc, 32'h8);
    set_in(2'b10, 1'b0, 1'b0, 1'b1, 26'h000_FFFE, 32'h0, 1'b0, 1'b0);
    tick();
    check("bne_not_taken", pc, 32'hC);

    // Unconditional PC-relative branch, forward offset.
    set_in(2'b11, 1'b1, 1'b1, 1'b1, 26'h000_0010, 32'h0, 1'b0, 1'b0);
    tick();
    check("uncond_branch", pc, 32'h50);

    // j from 0x1000_0010.
    jr_to(32'h1000_0010);
    check("jr_aligned", pc, 32'h1000_0010);
    set_in(2'b00, 1'b1, 1'b0, 1'b0, 26'h000_0040, 32'h0, 1'b0, 1'b0);
    #1;
    check("j_pcPlus4", pcPlus4, 32'h1000_0014);
    tick();
    check("j_target", pc, 32'h1000_0100);

    // Two-cycle stall at pc=20.
    jr_to(32'd20);
    set_in(2'b10, 1'b1, 1'b0, 1'b0, 26'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("stall1_pc", pc, 32'd20);
    check("stall1_fv", 32'(fetchValid), 32'h0);
    tick();
    check("stall2_pc", pc, 32'd20);
`ifdef PC_RETIRE_COUNT_EN
    ret_before = retired;
`endif
    seq_step();
    check("unstall_pc", pc, 32'd20);
    check("unstall_fv", 32'(fetchValid), 32'h1);
`ifdef PC_RETIRE_COUNT_EN
    check("stall_no_retire", retired, ret_before);
`endif
    seq_step();
    check("after_stall_pc", pc, 32'd24);

    // stall and halt on the same edge.
    jr_to(32'd20);
    set_in(2'b10, 1'b1, 1'b0, 1'b0, 26'h0, 32'h0, 1'b1, 1'b1);
    tick();
    check("halt_pc", pc, 32'd20);
    check("halt_flag", 32'(halted), 32'h1);
    seq_step();
    check("halt_absorb", pc, 32'd20);

    // Misaligned jr, then asynchronous reset mid-cycle.
    do_reset();
    seq_step();
    jr_to(32'h0000_0203);
    check("mis_fault", 32'(misalignFault), 32'h1);
    check("mis_halted", 32'(halted), 32'h1);
    check("mis_pc", pc, 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_fault", 32'(misalignFault), 32'h0);
    check("async_halted", 32'(halted), 32'h0);
    check("async_fv", 32'(fetchValid), 32'h0);
`ifdef PC_RETIRE_COUNT_EN
    check("async_retired", retired, 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    seq_step();

    // Wrap-around at the top of the address space.
    jr_to(32'hFFFF_FFFC);
`ifdef PC_RETIRE_COUNT_EN
    ret_before = retired;
`endif
    seq_step();
    check("wrap_pc", pc, 32'h0);
`ifdef PC_RETIRE_COUNT_EN
    check("wrap_retired", retired, ret_before + 32'd1);
`endif

    // Randomized traffic; model comparisons run every negedge.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rs;
      rs = $urandom();
      if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
      if ($urandom_range(0, 49) == 0) rs = 32'hFFFF_FFF0;
      set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
             26'($urandom()), rs, ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 149) == 0));
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
